seq_pattern_tx: RTL and testbench
=================================

// Module: seq_pattern_tx
// PURPOSE
//   Serial pattern transmitter. Serialises a PAT_W-bit pattern MSB-first onto a
//   1-bit line, repeated repeat_cnt times with GAP_LEN idle-0 cycles between
//   frames. Serves as the stimulus/transmit end for the team's serial sequence
//   detectors (default pattern 10110) and for on-chip loopback tests.
// PARAMETERS
//   PAT_W    5   pattern width in bits, >=2
//   CNT_W    4   width of repeat_cnt
//   GAP_LEN  2   idle-0 cycles between consecutive frames, >=0
// PORTS
//   clk         in   1      clock, rising edge
//   rst         in   1      reset, asynchronous, active-high
//   start       in   1      request; sampled only when busy=0
//   pattern     in   PAT_W  pattern to send, latched on accepted start
//   repeat_cnt  in   CNT_W  number of frames, latched on accepted start
//   dout        out  1      serial data, registered
//   dout_valid  out  1      high while dout carries a pattern/parity bit
//   busy        out  1      high from the cycle after start until done
//   done        out  1      one-cycle pulse after the last bit (or empty job)
// BEHAVIOUR
//   - Reset: all outputs 0, FSM=IDLE, shift/bit/frame counters cleared.
//     Asynchronous; mid-frame reset aborts the job immediately with no done pulse.
//   - FSM: IDLE, SHIFT, PARITY (only with the macro), GAP, DONE.
//   - IDLE: dout=0, dout_valid=0. start=1 at edge t latches pattern, repeat_cnt.
//     repeat_cnt!=0 -> SHIFT, busy=1 from t+1, first bit (pattern[PAT_W-1]) on
//     dout at t+1. repeat_cnt==0 -> DONE: busy=1, done=1 for one cycle at t+1,
//     dout_valid never asserts.
//   - SHIFT: one bit per cycle, MSB first, dout_valid=1; PAT_W cycles per frame.
//     After bit 0: PARITY if enabled, else GAP if frames remain (GAP_LEN>0),
//     else straight into the next frame's SHIFT, else DONE.
//   - GAP: dout=0, dout_valid=0 for exactly GAP_LEN cycles; no gap after the
//     last frame.
//   - DONE: done=1, busy=1 for that one cycle; next cycle IDLE with busy=0.
//     A start in the DONE cycle is ignored; start is accepted again from the
//     first IDLE cycle.
//   - start while busy=1: ignored. pattern/repeat_cnt changes mid-job have no
//     effect because working copies are used.
//   - Frame counter counts down from the latched repeat_cnt. At max
//     (2^CNT_W-1) it sends that many frames with no wrap.
//   - Job length in cycles, start to done:
//     F*(PAT_W+P) + (F-1)*GAP_LEN + 1, where P=1 with parity, else 0.
// CONFIGURATION
//   SEQ_TX_PARITY_EN defined: after each frame's PAT_W bits, one PARITY cycle
//     drives the even-parity bit (^pattern) with dout_valid=1. It is counted in
//     the job length.
//   SEQ_TX_PARITY_EN undefined: no PARITY state, frames are exactly PAT_W bits.
// TESTING
//   1 pattern=10110, repeat_cnt=1, start at t -> dout 1,0,1,1,0 at t+1..t+5,
//     dout_valid=1 there; done=1 at t+6; busy=0 at t+7.
//   2 pattern=10110, repeat_cnt=2, GAP_LEN=2 -> dout 1,0,1,1,0,0,0,1,0,1,1,0;
//     dout_valid low only on the 2 gap cycles; done at t+13.
//   3 repeat_cnt=0 -> done=1 at t+1, dout_valid stays 0, busy=0 at t+2.
//   4 start pulsed again at t+3 of test 1 with pattern=11111 -> ignored; output
//     identical to test 1; a new start after done starts a fresh job.
//   5 rst asserted at t+3 of test 1 -> dout, dout_valid, busy drop to 0 at
//     once; no done pulse; a fresh start after release sends the full frame.
//   6 SEQ_TX_PARITY_EN, pattern=10110, repeat_cnt=1 -> dout 1,0,1,1,0,1 at
//     t+1..t+6, dout_valid=1 all six; done at t+7.

Source files
------------

// File: rtl/seq_pattern_tx_if.sv
// Handshake/data bundle for seq_pattern_tx: job request in, serial line and status out.
interface seq_pattern_tx_if #(
  parameter int unsigned PAT_W = 5,
  parameter int unsigned CNT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             done;

  // Requester side: issues jobs, watches the line.
  modport master (
    output start, pattern, repeat_cnt,
    input  dout, dout_valid, busy, done
  );

  // Transmitter side.
  modport slave (
    input  start, pattern, repeat_cnt,
    output dout, dout_valid, busy, done
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a PAT_W-bit pattern MSB-first, repeat_cnt times,
// with GAP_LEN idle-0 cycles between frames and a one-cycle done pulse at the end.
// Optional feature macro SEQ_TX_PARITY_EN: appends an even-parity bit to every frame.
module seq_pattern_tx #(
  parameter int unsigned PAT_W   = 5,
  parameter int unsigned CNT_W   = 4,
  parameter int unsigned GAP_LEN = 2
) (
  input logic             clk,
  input logic             rst,
  seq_pattern_tx_if.slave bus
);

  localparam int unsigned BitW = $clog2(PAT_W);
  localparam int unsigned GapW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

`ifdef SEQ_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StShift, StParity, StGap, StDone} state_e;
`else
  typedef enum logic [1:0] {StIdle, StShift, StGap, StDone} state_e;
`endif

  state_e           state_q;
  logic [PAT_W-1:0] pat_q;        // working copy of the pattern for the whole job
  logic [PAT_W-2:0] shift_q;      // bits still to send in the current frame, next at MSB
  logic [BitW-1:0]  bit_cnt_q;    // bits remaining after the one on dout
  logic [CNT_W-1:0] frame_cnt_q;  // frames remaining, including the current one
  logic [GapW-1:0]  gap_cnt_q;    // gap cycles remaining after the current one
  logic             dout_q;
  logic             dout_valid_q;
  logic             busy_q;
  logic             done_q;

  logic frame_end;
  logic last_frame;

  // The cycle carrying the final bit of a frame decides what follows it.
`ifdef SEQ_TX_PARITY_EN
  assign frame_end  = (state_q == StParity);
`else
  assign frame_end  = (state_q == StShift) && (bit_cnt_q == '0);
`endif
  assign last_frame = (frame_cnt_q == CNT_W'(1));

  // Main FSM; every output is a register updated here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      pat_q        <= '0;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      frame_cnt_q  <= '0;
      gap_cnt_q    <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else if (frame_end) begin
      if (!last_frame) begin
        frame_cnt_q <= frame_cnt_q - 1'b1;
        if (GAP_LEN > 0) begin
          state_q      <= StGap;
          dout_q       <= 1'b0;
          dout_valid_q <= 1'b0;
          gap_cnt_q    <= GapW'(GAP_LEN - 1);
        end else begin
          // Back-to-back frames: reload straight from the working copy.
          state_q      <= StShift;
          shift_q      <= pat_q[PAT_W-2:0];
          dout_q       <= pat_q[PAT_W-1];
          dout_valid_q <= 1'b1;
          bit_cnt_q    <= BitW'(PAT_W - 1);
        end
      end else begin
        state_q      <= StDone;
        dout_q       <= 1'b0;
        dout_valid_q <= 1'b0;
        done_q       <= 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            pat_q       <= bus.pattern;
            frame_cnt_q <= bus.repeat_cnt;
            busy_q      <= 1'b1;
            if (bus.repeat_cnt == '0) begin
              // Empty job: straight to the done pulse, line stays idle.
              state_q <= StDone;
              done_q  <= 1'b1;
            end else begin
              state_q      <= StShift;
              shift_q      <= bus.pattern[PAT_W-2:0];
              dout_q       <= bus.pattern[PAT_W-1];
              dout_valid_q <= 1'b1;
              bit_cnt_q    <= BitW'(PAT_W - 1);
            end
          end
        end
        StShift: begin
`ifdef SEQ_TX_PARITY_EN
          if (bit_cnt_q == '0) begin
            state_q <= StParity;
            dout_q  <= ^pat_q;
          end else begin
`else
          begin
`endif
            dout_q    <= shift_q[PAT_W-2];
            shift_q   <= shift_q << 1;
            bit_cnt_q <= bit_cnt_q - 1'b1;
          end
        end
        StGap: begin
          if (gap_cnt_q != '0) begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end else begin
            state_q      <= StShift;
            shift_q      <= pat_q[PAT_W-2:0];
            dout_q       <= pat_q[PAT_W-1];
            dout_valid_q <= 1'b1;
            bit_cnt_q    <= BitW'(PAT_W - 1);
          end
        end
        StDone: begin
          // start is deliberately not looked at here.
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx (PAT_W=5, CNT_W=4, GAP_LEN=2).
module tb_seq_pattern_tx;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  seq_pattern_tx_if #(.PAT_W(5), .CNT_W(4)) bus ();

  seq_pattern_tx #(
    .PAT_W  (5),
    .CNT_W  (4),
    .GAP_LEN(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Hand-computed line contents (dout, dout_valid) per cycle, first cycle at the MSB.
`ifdef SEQ_TX_PARITY_EN
  localparam int          N1  = 6;
  localparam logic [31:0] D1  = 32'b101101;
  localparam logic [31:0] V1  = 32'b111111;
  localparam int          N2  = 14;
  localparam logic [31:0] D2  = 32'b10110100101101;
  localparam logic [31:0] V2  = 32'b11111100111111;
  localparam logic [31:0] DF  = 32'b010010;
  localparam int          MAX_DONE  = 119;
  localparam int          MAX_VALID = 90;
`else
  localparam int          N1  = 5;
  localparam logic [31:0] D1  = 32'b10110;
  localparam logic [31:0] V1  = 32'b11111;
  localparam int          N2  = 12;
  localparam logic [31:0] D2  = 32'b101100010110;
  localparam logic [31:0] V2  = 32'b111110011111;
  localparam logic [31:0] DF  = 32'b01001;
  localparam int          MAX_DONE  = 104;
  localparam int          MAX_VALID = 75;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] obs();
    return {28'd0, bus.dout, bus.dout_valid, bus.busy, bus.done};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a job and check every cycle through the done pulse; optionally pulse a
  // second start (pattern 11111) at edge t+inj_at+1.
  task automatic run_job(input string tag, input logic [4:0] pat, input logic [3:0] cnt,
                         input logic [31:0] exp_d, input logic [31:0] exp_v, input int n,
                         input int inj_at);
    bus.pattern    = pat;
    bus.repeat_cnt = cnt;
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
    bus.pattern    = ~pat;
    bus.repeat_cnt = ~cnt;
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s cyc%0d", tag, i + 1), obs(),
            {28'd0, exp_d[n-1-i], exp_v[n-1-i], 2'b10});
      if (i == inj_at) begin
        bus.start   = 1'b1;
        bus.pattern = 5'b11111;
      end
      tick();
      if (i == inj_at) bus.start = 1'b0;
    end
    check($sformatf("%s done", tag), obs(), 32'b0011);
  endtask

  initial begin
    int done_at;
    int valid_seen;

    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.pattern    = '0;
    bus.repeat_cnt = '0;
    #12;
    check("reset state", obs(), 32'b0000);
    rst = 1'b0;
    tick();
    check("idle after reset", obs(), 32'b0000);

    // 1: single frame
    run_job("t1", 5'b10110, 4'd1, D1, V1, N1, -1);
    tick();
    check("t1 idle", obs(), 32'b0000);

    // 2: two frames with gap
    run_job("t2", 5'b10110, 4'd2, D2, V2, N2, -1);
    tick();
    check("t2 idle", obs(), 32'b0000);

    // 3: empty job
    run_job("t3", 5'b10110, 4'd0, '0, '0, 0, -1);
    tick();
    check("t3 idle", obs(), 32'b0000);

    // 4: start while busy ignored; start in done cycle ignored; fresh job accepted
    run_job("t4", 5'b10110, 4'd1, D1, V1, N1, 2);
    bus.start      = 1'b1;
    bus.pattern    = 5'b01001;
    bus.repeat_cnt = 4'd1;
    tick();
    check("t4 start in done ignored", obs(), 32'b0000);
    run_job("t4 fresh", 5'b01001, 4'd1, DF, V1, N1, -1);
    tick();
    check("t4 idle", obs(), 32'b0000);

    // 5: asynchronous reset mid-frame
    bus.pattern    = 5'b10110;
    bus.repeat_cnt = 4'd1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    check("t5 cyc1", obs(), 32'b1110);
    tick();
    tick();
    check("t5 cyc3", obs(), 32'b1110);
    #2 rst = 1'b1;
    #1;
    check("t5 async rst", obs(), 32'b0000);
    tick();
    tick();
    check("t5 no done", obs(), 32'b0000);
    #2 rst = 1'b0;
    tick();
    run_job("t5 fresh", 5'b10110, 4'd1, D1, V1, N1, -1);
    tick();
    check("t5 idle", obs(), 32'b0000);

    // Max repeat count: no wrap, full job length
    bus.pattern    = 5'b10110;
    bus.repeat_cnt = 4'd15;
    bus.start      = 1'b1;
    tick();
    bus.start  = 1'b0;
    done_at    = -1;
    valid_seen = 0;
    for (int c = 1; c <= 300; c++) begin
      if (bus.dout_valid) valid_seen++;
      if (bus.done) begin
        done_at = c;
        break;
      end
      tick();
    end
    check("max done cycle", done_at, MAX_DONE);
    check("max valid cycles", valid_seen, MAX_VALID);
    tick();
    check("max idle", obs(), 32'b0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
